mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter XLEN, 32, data/register width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, 32, byte-address width.
REQ-003 Parameter SPLIT_MISALIGNED, 1, 1 = misaligned access becomes two memory beats; 0 = flagged as error, no memory access.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  execute stage presents a memory op.
REQ-007 req_ready  out  1  unit accepts op this cycle (IDLE only).
REQ-008 opcode  in  7  RISC-V opcode; LOAD and STORE act, any other opcode passes through.
REQ-009 funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
REQ-010 res  in  ADDR_W  effective address from ALU.
REQ-011 x2  in  XLEN  store data, right-justified.
REQ-012 d_req  out  1  memory request strobe, held until d_ack.
REQ-013 d_address  out  ADDR_W  lane-aligned beat address (low log2(XLEN/8) bits zero).
REQ-014 d_data_write  out  XLEN  lane-positioned store data.
REQ-015 d_byte_en  out  XLEN/8  active byte lanes.
REQ-016 d_write_enable  out  1  beat is a store.
REQ-017 d_ack  in  1  memory completes the current beat; d_data_read valid same cycle.
REQ-018 d_data_read  in  XLEN  read data, full lane width.
REQ-019 rsp_valid  out  1  one-cycle pulse: op complete.
REQ-020 rsp_data  out  XLEN  extended load result; zero for stores and non-memory ops.
REQ-021 misalign_err  out  1  one-cycle pulse with rsp_valid when SPLIT_MISALIGNED=0 and access crosses a lane boundary.

Function
REQ-022 NB = XLEN/8; off = res mod NB; size S in bytes from funct3; access crosses when off+S > NB.
REQ-023 FSM states IDLE, BEAT1, BEAT2, RESP; req_ready=1 only in IDLE.
REQ-024 IDLE: req_valid with LOAD/STORE -> latch op -> BEAT1; with other opcode -> RESP, no memory access; crossing and SPLIT_MISALIGNED=0 -> RESP with misalign_err, no memory access.
REQ-025 BEAT1: d_req=1, d_address=res with low bits cleared, d_byte_en=(2^S-1)<<off truncated to NB bits, d_data_write=x2<<(8*off).
REQ-026 BEAT1 on d_ack: crossing -> BEAT2; otherwise -> RESP.
REQ-027 BEAT2: d_address=BEAT1 address+NB (wraps modulo 2^ADDR_W), d_byte_en=(2^S-1)>>(NB-off), d_data_write=x2>>(8*(NB-off)).
REQ-028 Load bytes captured per beat on d_ack, only enabled lanes; assembled value is sign-extended (B/H/W) or zero-extended (BU/HU/WU) to XLEN.
REQ-029 RESP: rsp_valid=1 for exactly one cycle, then IDLE; minimum latency accept->rsp_valid = 2 cycles for 1 beat with d_ack in first BEAT1 cycle, 3 for 2 beats.
REQ-030 d_req, address, data, byte_en and write_enable stable while waiting for d_ack; arbitrary wait states permitted.
REQ-031 d_ack outside BEAT1/BEAT2 ignored.
REQ-032 Illegal funct3 (011/110 with XLEN=32, 111) -> treated as misaligned-error path: no access, misalign_err pulse.

Reset
REQ-033 reset_n low at a clock edge: state IDLE, d_req 0, d_write_enable 0, d_byte_en 0, d_address 0, d_data_write 0, rsp_valid 0, rsp_data 0, misalign_err 0, mid-transaction included; in-flight op discarded, no response.

Structure
REQ-034 Shared package holds opcode constants (LOAD, STORE), funct3 size codes, and FSM state enum.
REQ-035 Sub-module mem_lane_align: combinational byte-enable/data shift generator for one beat, instantiated once.

Verification
REQ-036 XLEN=32, SW x2=0xDEADBEEF res=0x100, d_ack immediate -> one beat, byte_en 1111, data 0xDEADBEEF, rsp_valid cycle 2.
REQ-037 LB res=0x103, d_data_read=0x80000000 -> byte_en 1000, rsp_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SPLIT=1, SW x2=0x11223344 res=0x102 -> beat1 addr 0x100 be 1100 data 0x33440000; beat2 addr 0x104 be 0011 data 0x00001122.
REQ-039 SPLIT=0, LH res=0x103 -> no d_req, rsp_valid+misalign_err pulse, rsp_data 0.
REQ-040 LW with d_ack delayed 5 cycles, reset_n low during cycle 3 -> outputs zero next edge, no rsp_valid, next op served normally.
REQ-041 XLEN=64, LD res=0x8 -> byte_en 0xFF, full 64-bit rsp_data; LWU res=0xC, d_data_read upper word 0xFFFFFFFF -> rsp_data 0x00000000FFFFFFFF.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_unit_pkg                                                   |
// | Opcode constants, funct3 size codes and FSM states for the load/store |
// | unit.                                                                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package mem_access_unit_pkg;

  // RISC-V major opcodes the unit acts on
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;

  // funct3 size/sign codes
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_d  = 3'b011;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;
  localparam logic [2:0] c_f3_wu = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_RESP  = 2'd3
  } mau_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_lane_align                                                        |
// | Byte-enable and store-data lane positioning for one memory beat.      |
// | The access is laid out across two lane-widths; the first beat takes   |
// | the low half, the second beat the spill-over high half.               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_lane_align #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [1:0]                sz,
  input  logic                      second,
  input  logic [XLEN-1:0]           wdata,
  output logic [XLEN/8-1:0]         byte_en,
  output logic [XLEN-1:0]           data
);
  localparam int NB = XLEN / 8;

  logic [2*NB-1:0]   w_mask;
  logic [2*NB-1:0]   w_be_wide;
  logic [2*XLEN-1:0] w_data_wide;

  // unshifted lane mask of 2^S-1 for the access size
  always_comb begin
    w_mask = '0;
    case (sz)
      2'd0:    w_mask = (2*NB)'(8'h01);
      2'd1:    w_mask = (2*NB)'(8'h03);
      2'd2:    w_mask = (2*NB)'(8'h0F);
      default: w_mask = (2*NB)'(8'hFF);
    endcase
  end

  assign w_be_wide   = w_mask << off;
  assign w_data_wide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};

  assign byte_en = second ? w_be_wide[2*NB-1:NB]       : w_be_wide[NB-1:0];
  assign data    = second ? w_data_wide[2*XLEN-1:XLEN] : w_data_wide[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_access_unit                                                       |
// | Load/store unit: lane-aligns accesses, splits or rejects lane-        |
// | crossing accesses, and assembles/extends load data.                   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [ADDR_W-1:0]   res,
  input  logic [XLEN-1:0]     x2,
  output logic                d_req,
  output logic [ADDR_W-1:0]   d_address,
  output logic [XLEN-1:0]     d_data_write,
  output logic [XLEN/8-1:0]   d_byte_en,
  output logic                d_write_enable,
  input  logic                d_ack,
  input  logic [XLEN-1:0]     d_data_read,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_data,
  output logic                misalign_err
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  mau_state_t        state;
  logic [OFFW-1:0]   r_off;
  logic [1:0]        r_sz;
  logic              r_unsigned;
  logic              r_is_load;
  logic              r_cross;
  logic [XLEN-1:0]   r_x2;
  logic [2*XLEN-1:0] r_ld_buf;

  logic              w_is_load, w_is_store, w_is_mem, w_legal, w_cross, w_err;
  logic [OFFW-1:0]   w_off;
  logic [4:0]        w_sum;
  logic [OFFW-1:0]   w_la_off;
  logic [1:0]        w_la_sz;
  logic [XLEN-1:0]   w_la_wdata, w_la_data;
  logic [NB-1:0]     w_la_be;
  logic [2*XLEN-1:0] w_buf_next;
  logic [XLEN-1:0]   w_raw, w_lo_mask, w_load_val;
  logic              w_sign;

  assign req_ready  = (state == ST_IDLE);
  assign w_is_load  = (opcode == c_op_load);
  assign w_is_store = (opcode == c_op_store);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_off      = res[OFFW-1:0];
  assign w_sum      = 5'(w_off) + (5'd1 << funct3[1:0]);
  assign w_cross    = (w_sum > 5'(NB));

  // size codes that exist for this register width
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      c_f3_b, c_f3_h, c_f3_w, c_f3_bu, c_f3_hu: w_legal = 1'b1;
      c_f3_d, c_f3_wu:                           w_legal = (XLEN == 64);
      default:                                   w_legal = 1'b0;
    endcase
  end

  assign w_err = w_is_mem && (!w_legal || (w_cross && (SPLIT_MISALIGNED == 0)));

  // In IDLE the aligner prepares beat 1 from the live request; in BEAT1 it
  // prepares beat 2 from the latched op.
  assign w_la_off   = (state == ST_IDLE) ? w_off       : r_off;
  assign w_la_sz    = (state == ST_IDLE) ? funct3[1:0] : r_sz;
  assign w_la_wdata = (state == ST_IDLE) ? x2          : r_x2;

  mem_lane_align #(.XLEN(XLEN)) u_lane_align (
    .off     (w_la_off),
    .sz      (w_la_sz),
    .second  (state == ST_BEAT1),
    .wdata   (w_la_wdata),
    .byte_en (w_la_be),
    .data    (w_la_data)
  );

  // merge the enabled lanes of the current beat into the two-lane load buffer
  always_comb begin
    w_buf_next = r_ld_buf;
    for (int i = 0; i < NB; i++) begin
      if (d_byte_en[i]) begin
        if (state == ST_BEAT2) w_buf_next[8*(NB+i) +: 8] = d_data_read[8*i +: 8];
        else                   w_buf_next[8*i +: 8]      = d_data_read[8*i +: 8];
      end
    end
  end

  assign w_raw = XLEN'(w_buf_next >> {r_off, 3'b000});

  // sign- or zero-extend the assembled load value to XLEN
  always_comb begin
    w_lo_mask = '1;
    w_sign    = 1'b0;
    case (r_sz)
      2'd0:    begin w_lo_mask = XLEN'(8'hFF);         w_sign = w_raw[7];      end
      2'd1:    begin w_lo_mask = XLEN'(16'hFFFF);      w_sign = w_raw[15];     end
      2'd2:    begin w_lo_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_raw[31];     end
      default: begin w_lo_mask = '1;                   w_sign = w_raw[XLEN-1]; end
    endcase
    w_load_val = (w_raw & w_lo_mask) | ((w_sign && !r_unsigned) ? ~w_lo_mask : '0);
  end

  // access FSM with registered memory-side and response outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      d_req          <= 1'b0;
      d_address      <= '0;
      d_data_write   <= '0;
      d_byte_en      <= '0;
      d_write_enable <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      misalign_err   <= 1'b0;
      r_off          <= '0;
      r_sz           <= '0;
      r_unsigned     <= 1'b0;
      r_is_load      <= 1'b0;
      r_cross        <= 1'b0;
      r_x2           <= '0;
      r_ld_buf       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (!w_is_mem || w_err) begin
              // pass-through or rejected access: respond without touching memory
              state        <= ST_RESP;
              rsp_valid    <= 1'b1;
              rsp_data     <= '0;
              misalign_err <= w_err;
            end else begin
              state          <= ST_BEAT1;
              r_off          <= w_off;
              r_sz           <= funct3[1:0];
              r_unsigned     <= funct3[2];
              r_is_load      <= w_is_load;
              r_cross        <= w_cross;
              r_x2           <= x2;
              r_ld_buf       <= '0;
              d_req          <= 1'b1;
              d_address      <= {res[ADDR_W-1:OFFW], {OFFW{1'b0}}};
              d_byte_en      <= w_la_be;
              d_data_write   <= w_la_data;
              d_write_enable <= w_is_store;
            end
          end
        end
        ST_BEAT1: begin
          if (d_ack) begin
            r_ld_buf <= w_buf_next;
            if (r_cross) begin
              state        <= ST_BEAT2;
              d_address    <= d_address + ADDR_W'(NB);
              d_byte_en    <= w_la_be;
              d_data_write <= w_la_data;
            end else begin
              state          <= ST_RESP;
              d_req          <= 1'b0;
              d_address      <= '0;
              d_byte_en      <= '0;
              d_data_write   <= '0;
              d_write_enable <= 1'b0;
              rsp_valid      <= 1'b1;
              rsp_data       <= r_is_load ? w_load_val : '0;
            end
          end
        end
        ST_BEAT2: begin
          if (d_ack) begin
            state          <= ST_RESP;
            d_req          <= 1'b0;
            d_address      <= '0;
            d_byte_en      <= '0;
            d_data_write   <= '0;
            d_write_enable <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_data       <= r_is_load ? w_load_val : '0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          rsp_valid    <= 1'b0;
          rsp_data     <= '0;
          misalign_err <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_access_unit                                                    |
// | Directed bench: a 32-bit splitting unit and a 64-bit rejecting unit   |
// | share stimulus; expected responses are queued when an op is driven    |
// | and compared when the unit responds.                                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;          // 0: 32-bit unit, 1: 64-bit unit
  logic        req_valid = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] res = '0;
  logic [63:0] x2 = '0;
  logic        d_ack = 1'b0;
  logic [63:0] d_data_read = '0;

  logic        rr32, dr32, we32, rv32, me32;
  logic [31:0] da32, dw32, rs32;
  logic [3:0]  be32;
  logic        rr64, dr64, we64, rv64, me64;
  logic [31:0] da64;
  logic [63:0] dw64, rs64;
  logic [7:0]  be64;

  logic        req_valid32, req_valid64, d_ack32, d_ack64;
  logic        m_ready, m_d_req, m_we, m_rsp_valid, m_err;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, m_rsp_data;
  logic [7:0]  m_be;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } rsp_t;
  rsp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign req_valid32 = req_valid & ~sel;
  assign req_valid64 = req_valid & sel;
  assign d_ack32     = d_ack & ~sel;
  assign d_ack64     = d_ack & sel;

  assign m_ready     = sel ? rr64 : rr32;
  assign m_d_req     = sel ? dr64 : dr32;
  assign m_we        = sel ? we64 : we32;
  assign m_addr      = sel ? da64 : da32;
  assign m_wdata     = sel ? dw64 : {32'h0, dw32};
  assign m_be        = sel ? be64 : {4'h0, be32};
  assign m_rsp_valid = sel ? rv64 : rv32;
  assign m_rsp_data  = sel ? rs64 : {32'h0, rs32};
  assign m_err       = sel ? me64 : me32;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1)) dut32 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid32), .req_ready(rr32),
    .opcode(opcode), .funct3(funct3), .res(res), .x2(x2[31:0]),
    .d_req(dr32), .d_address(da32), .d_data_write(dw32), .d_byte_en(be32),
    .d_write_enable(we32), .d_ack(d_ack32), .d_data_read(d_data_read[31:0]),
    .rsp_valid(rv32), .rsp_data(rs32), .misalign_err(me32)
  );

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .SPLIT_MISALIGNED(0)) dut64 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid64), .req_ready(rr64),
    .opcode(opcode), .funct3(funct3), .res(res), .x2(x2),
    .d_req(dr64), .d_address(da64), .d_data_write(dw64), .d_byte_en(be64),
    .d_write_enable(we64), .d_ack(d_ack64), .d_data_read(d_data_read),
    .rsp_valid(rv64), .rsp_data(rs64), .misalign_err(me64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one op, play the memory for nb beats (dly wait states before
  // beat 1 ack), then compare the response against the scoreboard.
  task automatic run_op(input string tag, input logic s, input logic [6:0] op,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wd, input int nb, input int dly,
                        input logic [31:0] ea1, input logic [7:0] ebe1,
                        input logic [63:0] ed1, input logic [63:0] rd1,
                        input logic [31:0] ea2, input logic [7:0] ebe2,
                        input logic [63:0] ed2, input logic [63:0] rd2,
                        input logic [63:0] ersp, input logic eerr);
    int   cyc;
    rsp_t e;
    rsp_t g;
    @(negedge clk);
    sel = s; opcode = op; funct3 = f3; res = addr; x2 = wd; req_valid = 1'b1;
    e.data = ersp; e.err = eerr;
    sb_q.push_back(e);
    check({tag, ".req_ready"}, {63'h0, m_ready}, 64'h1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    for (int b = 0; b < nb; b++) begin
      if (b == 0) begin
        for (int w = 0; w < dly; w++) begin
          check({tag, ".wait_addr"}, {32'h0, m_addr}, {32'h0, ea1});
          check({tag, ".wait_be"}, {56'h0, m_be}, {56'h0, ebe1});
          d_ack = 1'b0;
          @(negedge clk);
          cyc++;
        end
      end
      check({tag, ".d_req"}, {63'h0, m_d_req}, 64'h1);
      check({tag, ".addr"}, {32'h0, m_addr}, {32'h0, (b == 0) ? ea1 : ea2});
      check({tag, ".be"}, {56'h0, m_be}, {56'h0, (b == 0) ? ebe1 : ebe2});
      check({tag, ".wdata"}, m_wdata, (b == 0) ? ed1 : ed2);
      check({tag, ".we"}, {63'h0, m_we}, {63'h0, (op == c_op_store)});
      d_ack = 1'b1;
      d_data_read = (b == 0) ? rd1 : rd2;
      @(negedge clk);
      d_ack = 1'b0;
      d_data_read = '0;
      cyc++;
    end
    if (nb == 0) check({tag, ".no_d_req"}, {63'h0, m_d_req}, 64'h0);
    for (int t = 0; t < 8 && !m_rsp_valid; t++) begin
      @(negedge clk);
      cyc++;
    end
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 64'h1, 64'h0);
    end else begin
      g = sb_q.pop_front();
      check({tag, ".rsp_valid"}, {63'h0, m_rsp_valid}, 64'h1);
      if (m_rsp_valid) begin
        check({tag, ".latency"}, 64'(cyc), 64'(1 + nb + dly));
        check({tag, ".rsp_data"}, m_rsp_data, g.data);
        check({tag, ".misalign_err"}, {63'h0, m_err}, {63'h0, g.err});
      end
    end
    @(negedge clk);
    check({tag, ".rsp_pulse"}, {63'h0, m_rsp_valid}, 64'h0);
  endtask

  initial begin
    int seen;
    // reset state of both units
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      sel = u[0];
      #0;
      check("reset.d_req", {63'h0, m_d_req}, 64'h0);
      check("reset.addr", {32'h0, m_addr}, 64'h0);
      check("reset.be", {56'h0, m_be}, 64'h0);
      check("reset.rsp_valid", {63'h0, m_rsp_valid}, 64'h0);
      check("reset.rsp_data", m_rsp_data, 64'h0);
      check("reset.err", {63'h0, m_err}, 64'h0);
    end
    reset_n = 1'b1;
    sel = 1'b0;

    // d_ack while idle must be ignored
    @(negedge clk);
    d_ack = 1'b1; d_data_read = '1;
    @(negedge clk);
    d_ack = 1'b0; d_data_read = '0;
    check("idle_ack.d_req", {63'h0, m_d_req}, 64'h0);
    check("idle_ack.rsp_valid", {63'h0, m_rsp_valid}, 64'h0);
    check("idle_ack.ready", {63'h0, m_ready}, 64'h1);

    // 32-bit unit, splitting enabled
    run_op("sw_aligned", 1'b0, c_op_store, c_f3_w, 32'h100, 64'hDEADBEEF, 1, 0,
           32'h100, 8'hF, 64'hDEADBEEF, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    run_op("lb_sign", 1'b0, c_op_load, c_f3_b, 32'h103, 64'h0, 1, 0,
           32'h100, 8'h8, 64'h0, 64'h80000000, 32'h0, 8'h0, 64'h0, 64'h0, 64'hFFFFFF80, 1'b0);
    run_op("lbu_zero", 1'b0, c_op_load, c_f3_bu, 32'h103, 64'h0, 1, 0,
           32'h100, 8'h8, 64'h0, 64'h80000000, 32'h0, 8'h0, 64'h0, 64'h0, 64'h00000080, 1'b0);
    run_op("lh_lane2", 1'b0, c_op_load, c_f3_h, 32'h2, 64'h0, 1, 0,
           32'h0, 8'hC, 64'h0, 64'h80010000, 32'h0, 8'h0, 64'h0, 64'h0, 64'hFFFF8001, 1'b0);
    run_op("sw_split", 1'b0, c_op_store, c_f3_w, 32'h102, 64'h11223344, 2, 2,
           32'h100, 8'hC, 64'h33440000, 64'h0, 32'h104, 8'h3, 64'h00001122, 64'h0, 64'h0, 1'b0);
    run_op("lw_split", 1'b0, c_op_load, c_f3_w, 32'h101, 64'h0, 2, 0,
           32'h100, 8'hE, 64'h0, 64'hAABBCCDD, 32'h104, 8'h1, 64'h0, 64'h11223344, 64'h44AABBCC, 1'b0);
    run_op("lh_split_sign", 1'b0, c_op_load, c_f3_h, 32'h103, 64'h0, 2, 0,
           32'h100, 8'h8, 64'h0, 64'h7F000000, 32'h104, 8'h1, 64'h0, 64'h000000FF, 64'hFFFFFF7F, 1'b0);
    run_op("sw_wrap", 1'b0, c_op_store, c_f3_w, 32'hFFFFFFFE, 64'hA1B2C3D4, 2, 0,
           32'hFFFFFFFC, 8'hC, 64'hC3D40000, 64'h0, 32'h0, 8'h3, 64'h0000A1B2, 64'h0, 64'h0, 1'b0);
    run_op("non_mem", 1'b0, 7'b0110011, c_f3_w, 32'h100, 64'h5, 0, 0,
           32'h0, 8'h0, 64'h0, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    run_op("illegal_ld32", 1'b0, c_op_load, c_f3_d, 32'h100, 64'h0, 0, 0,
           32'h0, 8'h0, 64'h0, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b1);

    // reset in the middle of a waiting load
    @(negedge clk);
    sel = 1'b0; opcode = c_op_load; funct3 = c_f3_w; res = 32'h200; x2 = '0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid.d_req_before", {63'h0, m_d_req}, 64'h1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid.d_req", {63'h0, m_d_req}, 64'h0);
    check("rst_mid.addr", {32'h0, m_addr}, 64'h0);
    check("rst_mid.be", {56'h0, m_be}, 64'h0);
    check("rst_mid.rsp_valid", {63'h0, m_rsp_valid}, 64'h0);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      d_ack = (c == 2);
      d_data_read = 64'hCAFEF00D;
      @(negedge clk);
      if (m_rsp_valid) seen++;
    end
    d_ack = 1'b0; d_data_read = '0;
    check("rst_mid.no_rsp", 64'(seen), 64'h0);
    run_op("lw_after_rst", 1'b0, c_op_load, c_f3_w, 32'h200, 64'h0, 1, 0,
           32'h200, 8'hF, 64'h0, 64'h12345678, 32'h0, 8'h0, 64'h0, 64'h0, 64'h12345678, 1'b0);

    // 64-bit unit, misaligned accesses rejected
    run_op("ld64", 1'b1, c_op_load, c_f3_d, 32'h8, 64'h0, 1, 0,
           32'h8, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 32'h0, 8'h0, 64'h0, 64'h0,
           64'h0123456789ABCDEF, 1'b0);
    run_op("lwu64", 1'b1, c_op_load, c_f3_wu, 32'hC, 64'h0, 1, 0,
           32'h8, 8'hF0, 64'h0, 64'hFFFFFFFF00000000, 32'h0, 8'h0, 64'h0, 64'h0,
           64'h00000000FFFFFFFF, 1'b0);
    run_op("lw64_sign", 1'b1, c_op_load, c_f3_w, 32'h4, 64'h0, 1, 0,
           32'h0, 8'hF0, 64'h0, 64'h8000000000000000, 32'h0, 8'h0, 64'h0, 64'h0,
           64'hFFFFFFFF80000000, 1'b0);
    run_op("sd64", 1'b1, c_op_store, c_f3_d, 32'h10, 64'h1122334455667788, 1, 0,
           32'h10, 8'hFF, 64'h1122334455667788, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    run_op("lh64_misalign", 1'b1, c_op_load, c_f3_h, 32'h107, 64'h0, 0, 0,
           32'h0, 8'h0, 64'h0, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b1);

    check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
